// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) / inverse S-box helpers for the
// iterative AES-128 inverse-cipher controller.
package aes_pkg;

  localparam int NR = 10;  // rounds (AES-128 only)
  localparam int NB = 4;   // state columns
  localparam int NK = 4;   // key words

  localparam int STATE_BITS = 32 * NB;
  localparam int KEY_BITS   = 32 * NK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  // Inverse S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] INV_SBOX_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TABLE[2047 - 8 * int'(x) -: 8];
  endfunction

  // Multiply by x (0x02) in GF(2^8) with the AES polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a small constant (InvMixColumns only needs 9, 11, 13, 14).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = '0;
    pw  = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ pw;
      pw = xtime(pw);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on the last round).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [STATE_BITS-1:0] state_in,
  input  logic [KEY_BITS-1:0]   round_key,
  input  logic                  last_round,
  output logic [STATE_BITS-1:0] state_out
);

  logic [STATE_BITS-1:0] keyed;
  logic [STATE_BITS-1:0] mixed;

  // Byte (r,c) lives at index 4c+r; row r rotates right by r, so it pulls from column c-r.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    keyed = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        keyed[STATE_BITS-1-8*(4*c+r) -: 8] =
          inv_sbox(state_in[STATE_BITS-1-8*(4*((c - r + NB) % NB) + r) -: 8]) ^
          round_key[KEY_BITS-1-8*(4*c+r) -: 8];
      end
    end
  end

  // InvMixColumns, column by column with the {14,11,13,9} circulant.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < NB; c++) begin
      a0 = keyed[STATE_BITS-1-32*c      -: 8];
      a1 = keyed[STATE_BITS-1-32*c - 8  -: 8];
      a2 = keyed[STATE_BITS-1-32*c - 16 -: 8];
      a3 = keyed[STATE_BITS-1-32*c - 24 -: 8];
      mixed[STATE_BITS-1-32*c -: 32] = {
        gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9),
        gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13),
        gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11),
        gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14)
      };
    end
  end

  assign state_out = last_round ? keyed : mixed;

endmodule

// File: rtl/aes_decr_iter_ctrl.sv
// Iterative AES-128 inverse-cipher controller: accepts a ciphertext, reuses one
// inverse-round datapath for all rounds while stepping the round-key select,
// and presents the plaintext on a valid/ready output.
module aes_decr_iter_ctrl
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  output logic [3:0]            key_sel,
  input  logic [KEY_BITS-1:0]   round_key,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [STATE_BITS-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [STATE_BITS-1:0] out_data,
  output logic                  busy
);

  ctrl_state_e           state_q, state_d;
  logic [3:0]            rnd_q, rnd_d;
  logic [STATE_BITS-1:0] st_q, st_d;
  logic [STATE_BITS-1:0] round_out;
  logic                  last_round;

  aes_inv_round u_round (
    .state_in   (st_q),
    .round_key  (round_key),
    .last_round (last_round),
    .state_out  (round_out)
  );

  // State register, round counter and cipher state; reset aborts any operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
    end
  end

  // Next-state, datapath load and handshake decode.
  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    st_d       = st_q;
    key_sel    = 4'(NR);
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    last_round = 1'b0;

    case (state_q)
      IDLE: begin
        busy     = 1'b0;
        in_ready = key_valid;
        // Initial AddRoundKey uses the last round key (key_sel = NR).
        if (in_valid && key_valid) begin
          st_d    = in_data ^ round_key;
          rnd_d   = 4'(NR - 1);
          state_d = ROUND;
        end
      end

      ROUND: begin
        key_sel = rnd_q;
        st_d    = round_out;
        // Counts down only; never wraps below zero.
        if (rnd_q != 4'd0) rnd_d = rnd_q - 4'd1;
        if (rnd_q <= 4'd1) state_d = FINAL;
      end

      FINAL: begin
        key_sel    = 4'd0;
        last_round = 1'b1;
        st_d       = round_out;
        state_d    = DONE;
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end

      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Plaintext comes straight from the state register; it only changes outside DONE.
  assign out_data = st_q;

endmodule
